axi_cacheline_bridge: RTL and testbench
=======================================

Name: axi_cacheline_bridge

Overview:
- Slave end of the cache-side AXI bus (rd_req/ret_valid/wr_req/wr_valid). Sits between the I/D caches and the AXI crossbar.
- Turns one cache-line refill into one 4-beat INCR AXI read burst, and one dirty-line writeback into one 4-beat INCR AXI write burst.
- Read and write paths are independent FSMs, each with at most one transaction outstanding.

Parameters:
LINE_WORDS, 4, beats per line, fixed; line data width = 32*LINE_WORDS = 128

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
rd_req  input  1  refill request
rd_addr  input  32  refill line address
rd_rdy  output  1  read path can accept rd_req
ret_valid  output  1  one-cycle pulse, ret_data valid
ret_data  output  128  refilled line; [31:0] = lowest-address word
wr_req  input  1  writeback request
wr_addr  input  32  writeback line address
wr_data  input  128  writeback line; [31:0] = lowest-address word
wr_rdy  output  1  write path can accept wr_req
wr_valid  output  1  one-cycle pulse, writeback complete (B received)
araddr  output  32  AXI read address
arlen  output  8  constant 3
arvalid  output  1  AXI AR valid
arready  input  1  AXI AR ready
rdata  input  32  AXI read data
rlast  input  1  AXI last read beat
rvalid  input  1  AXI R valid
rready  output  1  AXI R ready
awaddr  output  32  AXI write address
awlen  output  8  constant 3
awvalid  output  1  AXI AW valid
awready  input  1  AXI AW ready
wdata  output  32  AXI write data
wstrb  output  4  constant 4'b1111
wlast  output  1  AXI last write beat
wvalid  output  1  AXI W valid
wready  input  1  AXI W ready
bvalid  input  1  AXI B valid
bready  output  1  AXI B ready

Behaviour:
- Fixed outside this block by the crossbar wrapper: size = 4 bytes, burst = INCR, id = 0. rresp and bresp are ignored.
- Reset (resetn=0 at posedge, any state):
  - Both FSMs go to IDLE and the beat counters go to 0.
  - arvalid, rready, awvalid, wvalid, wlast, bready, ret_valid, wr_valid = 0; ret_data = 0.
  - In-flight AXI transactions are abandoned.
- Read FSM, states R_IDLE -> R_AR -> R_DATA -> R_RET -> R_IDLE:
  - rd_rdy = (state==R_IDLE) && !(write FSM not idle && rd_addr[31:4]==latched write addr[31:4]). This blocks a refill of a line whose writeback is still pending.
  - rd_req && rd_rdy: latch {rd_addr[31:4],4'b0} and go to R_AR.
  - R_AR: arvalid=1, araddr = latched address. On arready go to R_DATA.
  - R_DATA: rready=1. Each rvalid beat writes rdata into buffer word[cnt], then cnt++.
  - The beat with rlast, or the beat where cnt==3, goes to R_RET.
  - R_RET: ret_valid=1 for exactly one cycle, ret_data = buffer, then return to R_IDLE.
  - Minimum latency with an always-ready slave: rd_req at cycle 0; arvalid cycles 1..; beats cycles 2-5; ret_valid cycle 6.
  - ret_data holds its value until the next R_RET.
- Write FSM, states W_IDLE -> W_AW -> W_DATA -> W_B -> W_DONE -> W_IDLE:
  - wr_rdy = (state==W_IDLE).
  - wr_req && wr_rdy: latch {wr_addr[31:4],4'b0} and wr_data.
  - W_AW: awvalid=1 until awready.
  - W_DATA: wvalid=1, wdata = word[cnt]. cnt advances only on wready. wlast=1 when cnt==3; that handshake goes to W_B.
  - W_B: bready=1. On bvalid go to W_DONE.
  - W_DONE: wr_valid=1 for one cycle, then W_IDLE.
  - W is never asserted before the AW handshake completes.
- Boundary cases:
  - rd_req and wr_req in the same idle cycle to different lines: both accepted; AR and AW proceed concurrently.
  - Same line: the write is accepted and the read is held off; rd_rdy rises in the cycle after wr_valid.
  - Source-side stalls (rvalid low mid-burst) and sink-side stalls (wready low) hold cnt and data.
  - Requests while not ready are ignored; the cache holds its request until the ready handshake.

Test Plan:
- Refill 0x1FC0_0104, slave returns 0x11,0x22,0x33,0x44 with no stalls -> araddr=0x1FC0_0100, arlen=3, ret_valid at cycle 6 for one cycle, ret_data=0x00000044_00000033_00000022_00000011.
- Writeback 0x0000_2000 with data 0xDDDD_CCCC_BBBB_AAAA (word3..word0 as 32-bit words), wready low for 2 cycles before beat 2 -> wdata sequence AAAA,BBBB,CCCC,DDDD; wlast on beat 4 only; wr_valid one cycle after bvalid.
- Simultaneous rd_req 0x100 and wr_req 0x200 -> AR and AW both issued in cycle 1; ret_valid and wr_valid are each pulsed once.
- wr_req 0x300 then rd_req 0x30C while the write is pending -> rd_rdy=0 until after wr_valid; araddr=0x300 issued only after B.
- resetn low for 1 cycle during R_DATA after beat 2 -> all valids and readies 0 and rd_rdy=1 next cycle; a new refill completes normally.
- rvalid gaps of 3 cycles between each beat -> still exactly 4 beats captured and one ret_valid pulse.

Source files
------------

// File: rtl/axi_cacheline_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axi_cacheline_bridge
// Purpose  : Cache-side to AXI bridge. A line refill becomes one 4-beat INCR
//            read burst. A dirty-line writeback becomes one 4-beat INCR write
//            burst. The read and write paths are independent FSMs, and each
//            path has at most one transaction outstanding.
// Revision : 1.0 - initial release
// ============================================================================
module axi_cacheline_bridge #(
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  // cache read side
  input  logic                     rd_req,
  input  logic [31:0]              rd_addr,
  output logic                     rd_rdy,
  output logic                     ret_valid,
  output logic [32*LINE_WORDS-1:0] ret_data,
  // cache write side
  input  logic                     wr_req,
  input  logic [31:0]              wr_addr,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                     wr_rdy,
  output logic                     wr_valid,
  // AXI read channels
  output logic [31:0]              araddr,
  output logic [7:0]               arlen,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [31:0]              rdata,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  // AXI write channels
  output logic [31:0]              awaddr,
  output logic [7:0]               awlen,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic                     bvalid,
  output logic                     bready
);

  localparam int                 c_cnt_w = $clog2(LINE_WORDS);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(LINE_WORDS - 1);
  localparam logic [7:0]         c_len   = 8'(LINE_WORDS - 1);
  localparam logic [31:0]        c_line_mask = 32'hFFFF_FFF0;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_RET} rstate_e;
  typedef enum logic [2:0] {W_IDLE, W_AW, W_DATA, W_B, W_DONE} wstate_e;

  rstate_e                     rstate_q, rstate_d;
  logic [31:0]                 raddr_q, raddr_d;
  logic [c_cnt_w-1:0]          rcnt_q, rcnt_d;
  logic [LINE_WORDS-1:0][31:0] rbuf_q, rbuf_d;
  logic [LINE_WORDS-1:0][31:0] rret_q, rret_d;

  wstate_e                     wstate_q, wstate_d;
  logic [31:0]                 waddr_q, waddr_d;
  logic [c_cnt_w-1:0]          wcnt_q, wcnt_d;
  logic [LINE_WORDS-1:0][31:0] wbuf_q, wbuf_d;

  logic                        line_busy;

  // A refill of a line whose writeback is still in flight has to wait.
  assign line_busy = (wstate_q != W_IDLE) && (rd_addr[31:4] == waddr_q[31:4]);

  assign araddr   = raddr_q;
  assign arlen    = c_len;
  assign awaddr   = waddr_q;
  assign awlen    = c_len;
  assign wstrb    = 4'b1111;
  assign wdata    = wbuf_q[wcnt_q];
  assign ret_data = rret_q;

  // Read path: next state, beat capture and channel outputs
  always_comb begin
    rstate_d  = rstate_q;
    raddr_d   = raddr_q;
    rcnt_d    = rcnt_q;
    rbuf_d    = rbuf_q;
    rret_d    = rret_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ret_valid = 1'b0;
    rd_rdy    = (rstate_q == R_IDLE) && !line_busy;
    unique case (rstate_q)
      R_IDLE: begin
        if (rd_req && rd_rdy) begin
          raddr_d  = rd_addr & c_line_mask;
          rcnt_d   = '0;
          rstate_d = R_AR;
        end
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) rstate_d = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          rbuf_d[rcnt_q] = rdata;
          rcnt_d         = rcnt_q + 1'b1;
          if (rlast || (rcnt_q == c_last)) begin
            rret_d   = rbuf_d;
            rstate_d = R_RET;
          end
        end
      end
      R_RET: begin
        ret_valid = 1'b1;
        rstate_d  = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Write path: next state, beat sequencing and channel outputs
  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    wcnt_d   = wcnt_q;
    wbuf_d   = wbuf_q;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    wlast    = 1'b0;
    bready   = 1'b0;
    wr_valid = 1'b0;
    wr_rdy   = (wstate_q == W_IDLE);
    unique case (wstate_q)
      W_IDLE: begin
        if (wr_req) begin
          waddr_d  = wr_addr & c_line_mask;
          wbuf_d   = wr_data;
          wcnt_d   = '0;
          wstate_d = W_AW;
        end
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) wstate_d = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        wlast  = (wcnt_q == c_last);
        if (wready) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == c_last) wstate_d = W_B;
        end
      end
      W_B: begin
        bready = 1'b1;
        if (bvalid) wstate_d = W_DONE;
      end
      W_DONE: begin
        wr_valid = 1'b1;
        wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rcnt_q   <= '0;
      rbuf_q   <= '0;
      rret_q   <= '0;
      wstate_q <= W_IDLE;
      waddr_q  <= '0;
      wcnt_q   <= '0;
      wbuf_q   <= '0;
    end else begin
      rstate_q <= rstate_d;
      raddr_q  <= raddr_d;
      rcnt_q   <= rcnt_d;
      rbuf_q   <= rbuf_d;
      rret_q   <= rret_d;
      wstate_q <= wstate_d;
      waddr_q  <= waddr_d;
      wcnt_q   <= wcnt_d;
      wbuf_q   <= wbuf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_cacheline_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_cacheline_bridge
// Purpose  : Directed self-checking bench for axi_cacheline_bridge
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_cacheline_bridge;

  logic         clk, resetn;
  logic         rd_req, rd_rdy, ret_valid;
  logic [31:0]  rd_addr;
  logic [127:0] ret_data;
  logic         wr_req, wr_rdy, wr_valid;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;
  logic [31:0]  araddr, rdata, awaddr, wdata;
  logic [7:0]   arlen, awlen;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]   wstrb;

  int n_cmp = 0;
  int n_bad = 0;

  axi_cacheline_bridge #(.LINE_WORDS(4)) dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .wr_valid(wr_valid),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rbeat(input logic [31:0] d, input logic last);
    tick();
    rvalid = 1'b1; rdata = d; rlast = last;
    #1;
    chk("rready_beat", rready, 1'b1);
    chk("ret_valid_beat", ret_valid, 1'b0);
  endtask

  task automatic wbeat(input logic [31:0] d, input logic last);
    tick();
    wready = 1'b1;
    #1;
    chk("wvalid_beat", wvalid, 1'b1);
    chk("wdata_beat", wdata, d);
    chk("wlast_beat", wlast, last);
  endtask

  // Full refill with an always-ready slave; words w0..w3 expected back
  task automatic refill(input logic [31:0] a, input logic [31:0] exp_a,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3);
    tick(); rd_req = 1'b1; rd_addr = a;
    #1; chk("rf_rd_rdy", rd_rdy, 1'b1);
    tick(); rd_req = 1'b0; arready = 1'b1;
    #1; chk("rf_arvalid", arvalid, 1'b1); chk("rf_araddr", araddr, exp_a);
    tick(); arready = 1'b0;
    rvalid = 1'b1; rdata = w0; rlast = 1'b0; #1; chk("rf_rready", rready, 1'b1);
    rbeat(w1, 1'b0); rbeat(w2, 1'b0); rbeat(w3, 1'b1);
    tick(); rvalid = 1'b0; rlast = 1'b0;
    #1; chk("rf_ret_valid", ret_valid, 1'b1);
    chk("rf_ret_data", ret_data, {w3, w2, w1, w0});
    tick(); #1; chk("rf_ret_valid_pulse", ret_valid, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0;
    wr_data = '0; arready = 1'b0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) tick();
    #1;
    chk("rst_arvalid", arvalid, 1'b0); chk("rst_rready", rready, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0); chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_wlast", wlast, 1'b0);     chk("rst_bready", bready, 1'b0);
    chk("rst_ret_valid", ret_valid, 1'b0); chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_ret_data", ret_data, 128'h0);
    chk("rst_rd_rdy", rd_rdy, 1'b1);   chk("rst_wr_rdy", wr_rdy, 1'b1);
    chk("rst_arlen", arlen, 8'd3);     chk("rst_awlen", awlen, 8'd3);
    chk("rst_wstrb", wstrb, 4'hF);
    resetn = 1'b1;

    // ---------------- T1: refill 0x1FC0_0104, cycle-exact ----------------
    tick(); rd_req = 1'b1; rd_addr = 32'h1FC0_0104;          // cycle 0
    #1; chk("t1_rd_rdy", rd_rdy, 1'b1); chk("t1_arvalid_c0", arvalid, 1'b0);
    tick(); rd_req = 1'b0; arready = 1'b1;                   // cycle 1
    #1; chk("t1_arvalid", arvalid, 1'b1); chk("t1_araddr", araddr, 32'h1FC0_0100);
    chk("t1_arlen", arlen, 8'd3); chk("t1_rd_rdy_busy", rd_rdy, 1'b0);
    tick(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h11; rlast = 1'b0;  // cycle 2
    #1; chk("t1_rready", rready, 1'b1); chk("t1_arvalid_off", arvalid, 1'b0);
    rbeat(32'h22, 1'b0); rbeat(32'h33, 1'b0); rbeat(32'h44, 1'b1);       // cycles 3-5
    tick(); rvalid = 1'b0; rlast = 1'b0;                     // cycle 6
    #1; chk("t1_ret_valid", ret_valid, 1'b1);
    chk("t1_ret_data", ret_data, 128'h00000044_00000033_00000022_00000011);
    chk("t1_rready_off", rready, 1'b0);
    tick(); #1;                                              // cycle 7
    chk("t1_ret_valid_pulse", ret_valid, 1'b0); chk("t1_rd_rdy_back", rd_rdy, 1'b1);
    chk("t1_ret_data_hold", ret_data, 128'h00000044_00000033_00000022_00000011);

    // ---------------- T2: writeback 0x2000 with a W stall ----------------
    tick(); wr_req = 1'b1; wr_addr = 32'h0000_2000;
    wr_data = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    #1; chk("t2_wr_rdy", wr_rdy, 1'b1);
    tick(); wr_req = 1'b0; awready = 1'b1;
    #1; chk("t2_awvalid", awvalid, 1'b1); chk("t2_awaddr", awaddr, 32'h2000);
    chk("t2_awlen", awlen, 8'd3); chk("t2_wvalid_early", wvalid, 1'b0);
    tick(); awready = 1'b0; wready = 1'b1;
    #1; chk("t2_awvalid_off", awvalid, 1'b0); chk("t2_wdata0", wdata, 32'hAAAAAAAA);
    chk("t2_wlast0", wlast, 1'b0); chk("t2_wstrb", wstrb, 4'hF);
    tick(); wready = 1'b0;
    #1; chk("t2_stall1_wdata", wdata, 32'hBBBBBBBB); chk("t2_stall1_wvalid", wvalid, 1'b1);
    tick();
    #1; chk("t2_stall2_wdata", wdata, 32'hBBBBBBBB); chk("t2_stall2_wlast", wlast, 1'b0);
    wbeat(32'hBBBBBBBB, 1'b0); wbeat(32'hCCCCCCCC, 1'b0); wbeat(32'hDDDDDDDD, 1'b1);
    tick(); wready = 1'b0; bvalid = 1'b1;
    #1; chk("t2_bready", bready, 1'b1); chk("t2_wvalid_off", wvalid, 1'b0);
    chk("t2_wr_valid_early", wr_valid, 1'b0);
    tick(); bvalid = 1'b0;
    #1; chk("t2_wr_valid", wr_valid, 1'b1); chk("t2_wr_rdy_busy", wr_rdy, 1'b0);
    tick(); #1; chk("t2_wr_valid_pulse", wr_valid, 1'b0); chk("t2_wr_rdy_back", wr_rdy, 1'b1);

    // ---------------- T3: concurrent read 0x100 and write 0x200 ----------------
    tick(); rd_req = 1'b1; rd_addr = 32'h100; wr_req = 1'b1; wr_addr = 32'h200;
    wr_data = {32'h8, 32'h7, 32'h6, 32'h5};
    #1; chk("t3_rd_rdy", rd_rdy, 1'b1); chk("t3_wr_rdy", wr_rdy, 1'b1);
    tick(); rd_req = 1'b0; wr_req = 1'b0; arready = 1'b1; awready = 1'b1;
    #1; chk("t3_arvalid", arvalid, 1'b1); chk("t3_awvalid", awvalid, 1'b1);
    chk("t3_araddr", araddr, 32'h100); chk("t3_awaddr", awaddr, 32'h200);
    tick(); arready = 1'b0; awready = 1'b0;
    rvalid = 1'b1; rdata = 32'h1; wready = 1'b1;
    #1; chk("t3_wdata0", wdata, 32'h5); chk("t3_rready", rready, 1'b1);
    tick(); rdata = 32'h2; #1; chk("t3_wdata1", wdata, 32'h6);
    tick(); rdata = 32'h3; #1; chk("t3_wdata2", wdata, 32'h7);
    tick(); rdata = 32'h4; rlast = 1'b1; #1; chk("t3_wdata3", wdata, 32'h8);
    chk("t3_wlast", wlast, 1'b1);
    tick(); rvalid = 1'b0; rlast = 1'b0; wready = 1'b0; bvalid = 1'b1;
    #1; chk("t3_ret_valid", ret_valid, 1'b1);
    chk("t3_ret_data", ret_data, {32'h4, 32'h3, 32'h2, 32'h1});
    chk("t3_wr_valid_early", wr_valid, 1'b0);
    tick(); bvalid = 1'b0;
    #1; chk("t3_ret_valid_pulse", ret_valid, 1'b0); chk("t3_wr_valid", wr_valid, 1'b1);
    tick(); #1; chk("t3_wr_valid_pulse", wr_valid, 1'b0);

    // ---------------- T4: same-line read held off by pending write ----------------
    tick(); wr_req = 1'b1; wr_addr = 32'h300; wr_data = {32'hD3, 32'hC3, 32'hB3, 32'hA3};
    tick(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 32'h30C;   // W_AW, aw held
    #1; chk("t4_rd_rdy_aw", rd_rdy, 1'b0);
    tick(); awready = 1'b1;
    #1; chk("t4_rd_rdy_aw2", rd_rdy, 1'b0); chk("t4_arvalid_aw", arvalid, 1'b0);
    wbeat(32'hA3, 1'b0);
    awready = 1'b0;
    #1; chk("t4_rd_rdy_w", rd_rdy, 1'b0);
    wbeat(32'hB3, 1'b0); wbeat(32'hC3, 1'b0); wbeat(32'hD3, 1'b1);
    tick(); wready = 1'b0; bvalid = 1'b1;
    #1; chk("t4_rd_rdy_b", rd_rdy, 1'b0); chk("t4_arvalid_b", arvalid, 1'b0);
    tick(); bvalid = 1'b0;
    #1; chk("t4_wr_valid", wr_valid, 1'b1); chk("t4_rd_rdy_done", rd_rdy, 1'b0);
    tick();
    #1; chk("t4_rd_rdy_rise", rd_rdy, 1'b1); chk("t4_arvalid_idle", arvalid, 1'b0);
    tick(); rd_req = 1'b0; arready = 1'b1;
    #1; chk("t4_arvalid", arvalid, 1'b1); chk("t4_araddr", araddr, 32'h300);
    tick(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hE0; rlast = 1'b0;
    rbeat(32'hE1, 1'b0); rbeat(32'hE2, 1'b0); rbeat(32'hE3, 1'b1);
    tick(); rvalid = 1'b0; rlast = 1'b0;
    #1; chk("t4_ret_valid", ret_valid, 1'b1);
    chk("t4_ret_data", ret_data, {32'hE3, 32'hE2, 32'hE1, 32'hE0});

    // ---------------- T5: reset mid-burst, then a clean refill ----------------
    tick(); rd_req = 1'b1; rd_addr = 32'h400;
    tick(); rd_req = 1'b0; arready = 1'b1;
    tick(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hF0;
    rbeat(32'hF1, 1'b0);
    tick(); rvalid = 1'b0; resetn = 1'b0;
    tick(); resetn = 1'b1;
    #1; chk("t5_arvalid", arvalid, 1'b0); chk("t5_rready", rready, 1'b0);
    chk("t5_ret_valid", ret_valid, 1'b0); chk("t5_rd_rdy", rd_rdy, 1'b1);
    chk("t5_wr_rdy", wr_rdy, 1'b1); chk("t5_ret_data", ret_data, 128'h0);
    refill(32'h504, 32'h500, 32'h51, 32'h52, 32'h53, 32'h54);

    // ---------------- T6: 3-cycle rvalid gaps between beats ----------------
    tick(); rd_req = 1'b1; rd_addr = 32'h608;
    tick(); rd_req = 1'b0; arready = 1'b1;
    #1; chk("t6_araddr", araddr, 32'h600);
    tick(); arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      repeat (3) begin
        tick(); rvalid = 1'b0; rlast = 1'b0;
        #1; chk("t6_gap_rready", rready, 1'b1); chk("t6_gap_ret_valid", ret_valid, 1'b0);
      end
      rbeat(32'h60 + 32'(b), (b == 3));
    end
    tick(); rvalid = 1'b0; rlast = 1'b0;
    #1; chk("t6_ret_valid", ret_valid, 1'b1);
    chk("t6_ret_data", ret_data, {32'h63, 32'h62, 32'h61, 32'h60});
    tick(); #1; chk("t6_ret_valid_pulse", ret_valid, 1'b0); chk("t6_rd_rdy", rd_rdy, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
